// File: rtl/fifo_rr_wr_arbiter_if.sv
// Requester streams plus FIFO write port shared by the round-robin write arbiter.
// master = producers/FIFO side, slave = arbiter.
interface fifo_rr_wr_arbiter_if #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned NumReq    = 4
);
  localparam int unsigned IdW = $clog2(NumReq);

  logic [NumReq-1:0]           req_valid;
  logic [NumReq-1:0]           req_last;
  logic [NumReq*DataWidth-1:0] req_data;
  logic [NumReq-1:0]           req_ready;
  logic                        fifo_full;
  logic                        fifo_w_en;
  logic [DataWidth-1:0]        fifo_data_in;
  logic [IdW-1:0]              grant_id;
  logic                        busy;

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_w_en, fifo_data_in, grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_w_en, fifo_data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NumReq valid/ready streams.
// A grant ends on end-of-packet, burst limit, or requester stall; each release passes through IDLE.
module fifo_rr_wr_arbiter #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned NumReq    = 4,
  parameter int unsigned MaxBurst  = 4
) (
  input logic                  clk,
  input logic                  clr_n,
  fifo_rr_wr_arbiter_if.slave  arb
);
  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(MaxBurst + 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e              r_state;
  logic [IdW-1:0]      r_grant_id;
  logic [IdW-1:0]      r_last_grant;
  logic [CntW-1:0]     r_beat_cnt;

  logic                w_busy;
  logic                w_gvalid;
  logic                w_glast;
  logic                w_xfer;
  logic                w_any;
  logic [IdW-1:0]      w_pick;
  logic [IdW-1:0]      w_sel;
  logic [CntW-1:0]     w_cnt_inc;
  logic [NumReq-1:0]   w_ready;
  logic [DataWidth-1:0] w_data;

  assign w_busy    = (r_state == StGrant);
  assign w_gvalid  = arb.req_valid[r_grant_id];
  assign w_glast   = arb.req_last[r_grant_id];
  assign w_xfer    = w_busy & w_gvalid & ~arb.fifo_full;
  assign w_cnt_inc = r_beat_cnt + 1'b1;
  assign w_data    = arb.req_data[r_grant_id * DataWidth +: DataWidth];

  // Scan from the requester after the last grant so the released one ends up last in line.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last_grant;
    w_sel  = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      w_sel = IdW'((32'(r_last_grant) + k) % NumReq);
      if (!w_any && arb.req_valid[w_sel]) begin
        w_any  = 1'b1;
        w_pick = w_sel;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_busy && !arb.fifo_full) w_ready[r_grant_id] = 1'b1;
  end

  assign arb.req_ready    = w_ready;
  assign arb.fifo_w_en    = w_xfer;
  assign arb.fifo_data_in = w_busy ? w_data : '0;
  assign arb.grant_id     = r_grant_id;
  assign arb.busy         = w_busy;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= StIdle;
      r_grant_id   <= '0;
      r_beat_cnt   <= '0;
      r_last_grant <= IdW'(NumReq - 1);
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_state    <= StGrant;
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
          end
        end
        StGrant: begin
          if (w_xfer) begin
            r_beat_cnt <= w_cnt_inc;
            if (w_glast || (w_cnt_inc == CntW'(MaxBurst))) begin
              r_state      <= StIdle;
              r_last_grant <= r_grant_id;
            end
          end else if (!w_gvalid) begin
            // Stall release; a full FIFO with valid held keeps the grant.
            r_state      <= StIdle;
            r_last_grant <= r_grant_id;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Directed bench for fifo_rr_wr_arbiter: per-cycle compare against a grant/budget model,
// plus hand-computed beat order, grant order and write spacing per scenario.
module tb_fifo_rr_wr_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  typedef logic [7:0] bq_t[$];
  typedef int iq_t[$];

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  fifo_rr_wr_arbiter_if #(.DataWidth(DW), .NumReq(N)) bus ();

  fifo_rr_wr_arbiter #(.DataWidth(DW), .NumReq(N), .MaxBurst(MB)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .arb   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0]   q[N][$];   // per-requester pending beats {last, data}
  logic [N-1:0] en      = '0;
  logic [N-1:0] s_ready = '0;
  bq_t  wlog, ed;
  iq_t  wcyc, glog, eg, egap;
  logic prev_busy = 1'b0;

  // Model: owner (-1 when idle), beats left in the grant budget, last released owner.
  int m_owner = -1;
  int m_left  = 0;
  int m_last  = N - 1;
  int m_grant = 0;

  logic [N-1:0]  e_ready;
  logic          e_wen;
  logic [DW-1:0] e_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic apply();
    logic [8:0] b;
    for (int i = 0; i < N; i++) begin
      if (en[i] && q[i].size() > 0) begin
        b = q[i][0];
        bus.req_valid[i]          = 1'b1;
        bus.req_last[i]           = b[8];
        bus.req_data[i*DW +: DW]  = b[7:0];
      end else begin
        bus.req_valid[i]          = 1'b0;
        bus.req_last[i]           = 1'b0;
        bus.req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && s_ready[i]) void'(q[i].pop_front());
    end
    #1;
    apply();
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    q[r].push_back({l, d});
  endtask

  task automatic check_logs(input string nm);
    chk({nm, "_nbeats"}, wlog.size(), ed.size());
    for (int k = 0; k < ed.size() && k < wlog.size(); k++)
      chk({nm, "_data"}, wlog[k], ed[k]);
    chk({nm, "_ngrants"}, glog.size(), eg.size());
    for (int k = 0; k < eg.size() && k < glog.size(); k++)
      chk({nm, "_grant"}, glog[k], eg[k]);
    for (int k = 0; k < egap.size() && k + 1 < wcyc.size(); k++)
      chk({nm, "_gap"}, wcyc[k+1] - wcyc[k], egap[k]);
    wlog.delete(); wcyc.delete(); glog.delete();
    ed.delete(); eg.delete(); egap.delete();
  endtask

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_owner <= -1;
      m_left  <= 0;
      m_last  <= N - 1;
      m_grant <= 0;
    end else if (m_owner < 0) begin
      if (pick(m_last, bus.req_valid) >= 0) begin
        m_owner <= pick(m_last, bus.req_valid);
        m_grant <= pick(m_last, bus.req_valid);
        m_left  <= MB;
      end
    end else if (bus.req_valid[m_owner] && !bus.fifo_full) begin
      m_left <= m_left - 1;
      if (bus.req_last[m_owner] || m_left == 1) begin
        m_owner <= -1;
        m_last  <= m_owner;
      end
    end else if (!bus.req_valid[m_owner]) begin
      m_owner <= -1;
      m_last  <= m_owner;
    end
  end

  always @(negedge clk) begin
    e_ready = '0;
    e_wen   = 1'b0;
    e_data  = '0;
    if (m_owner >= 0) begin
      if (!bus.fifo_full) e_ready[m_owner] = 1'b1;
      e_wen  = bus.req_valid[m_owner] && !bus.fifo_full;
      e_data = bus.req_data[m_owner*DW +: DW];
    end
    chk("busy", bus.busy, (m_owner >= 0));
    chk("req_ready", bus.req_ready, e_ready);
    chk("fifo_w_en", bus.fifo_w_en, e_wen);
    chk("fifo_data_in", bus.fifo_data_in, e_data);
    chk("grant_id", bus.grant_id, m_grant);
    s_ready = bus.req_ready;
    if (bus.fifo_w_en) begin
      wlog.push_back(bus.fifo_data_in);
      wcyc.push_back(cyc);
    end
    if (bus.busy && !prev_busy) glog.push_back(int'(bus.grant_id));
    prev_busy = bus.busy;
    cyc++;
  end

  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;

    // Reset with everyone valid, then round-robin over 1-beat packets.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) load(i, 8'(i*16 + k), 1'b1);
    en = '1;
    apply();
    tick();
    tick();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_wen", bus.fifo_w_en, 0);
    chk("rst_busy", bus.busy, 0);
    #1 clr_n = 1'b1;
    tick();
    chk("first_busy", bus.busy, 1);
    chk("first_grant", bus.grant_id, 0);
    repeat (26) tick();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) begin
        ed.push_back(8'(i*16 + k));
        eg.push_back(i);
      end
    for (int k = 0; k < 11; k++) egap.push_back(2);
    check_logs("rr");

    // Single 3-beat packet from requester 2.
    load(2, 8'hA1, 1'b0); load(2, 8'hA2, 1'b0); load(2, 8'hA3, 1'b1);
    apply();
    repeat (6) tick();
    ed = '{8'hA1, 8'hA2, 8'hA3};
    eg = '{2};
    egap = '{1, 1};
    check_logs("single");

    // Burst limit: 10 beats, no last.
    for (int k = 0; k < 10; k++) load(1, 8'(8'hB0 + k), 1'b0);
    apply();
    repeat (16) tick();
    for (int k = 0; k < 10; k++) ed.push_back(8'(8'hB0 + k));
    eg = '{1, 1, 1};
    egap = '{1, 1, 1, 2, 1, 1, 1, 2, 1};
    check_logs("burst");

    // Back-pressure for 3 cycles after the second beat; budget must not be consumed.
    for (int k = 0; k < 5; k++) load(3, 8'(8'hC0 + k), 1'b0);
    apply();
    tick();
    tick();
    tick();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_wen", bus.fifo_w_en, 0);
      chk("full_ready", bus.req_ready, 0);
      chk("full_grant", bus.grant_id, 3);
      tick();
    end
    bus.fifo_full = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 5; k++) ed.push_back(8'(8'hC0 + k));
    eg = '{3, 3};
    egap = '{1, 4, 1, 2};
    check_logs("bp");

    // Stall: requester 0 drops valid mid-packet, requester 1 waiting.
    load(0, 8'hD0, 1'b0); load(0, 8'hD1, 1'b0); load(1, 8'hE0, 1'b1);
    apply();
    tick();
    tick();
    en[0] = 1'b0;
    apply();
    #1;
    chk("stall_wen", bus.fifo_w_en, 0);
    chk("stall_busy", bus.busy, 1);
    tick();
    #1 chk("stall_idle", bus.busy, 0);
    tick();
    #1 chk("stall_next_grant", bus.grant_id, 1);
    en[0] = 1'b1;
    apply();
    repeat (6) tick();
    ed = '{8'hD0, 8'hE0, 8'hD1};
    eg = '{0, 1, 0};
    egap = '{3, 2};
    check_logs("stall");

    // Asynchronous reset between edges mid-burst.
    load(2, 8'hF0, 1'b0); load(2, 8'hF1, 1'b0); load(2, 8'hF2, 1'b0); load(2, 8'hF3, 1'b1);
    apply();
    tick();
    tick();
    #1 chk("pre_rst_wen", bus.fifo_w_en, 1);
    #1 clr_n = 1'b0;
    #1;
    chk("arst_wen", bus.fifo_w_en, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.req_ready, 0);
    chk("arst_data", bus.fifo_data_in, 0);
    clr_n = 1'b1;
    repeat (6) tick();
    ed = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
    eg = '{2, 2};
    egap = '{2, 1, 1};
    check_logs("arst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_rr_wr_arbiter.md
Name: fifo_rr_wr_arbiter

Overview:
Round-robin write arbiter that shares the write port of one syn_fifo among num_req requesters.
- Each requester presents a valid/ready stream with an end-of-packet marker.
- The arbiter grants one requester at a time and forwards its beats to the FIFO write port.
- A grant lasts until end-of-packet, burst limit, or the requester stalls.
- Sits between producer blocks and the syn_fifo instance (drives w_en/data_in, observes full).

Parameters:
data_width, 8, width of one data beat (matches FIFO data_width)
num_req, 4, number of requesters (2..16)
max_burst, 4, maximum beats per grant before forced release (>=1)

Ports:
clk  input  1  clock, rising edge
clr_n  input  1  asynchronous reset, active-low
req_valid  input  num_req  per-requester beat valid
req_last  input  num_req  per-requester end-of-packet, qualified by req_valid
req_data  input  num_req*data_width  requester i data at bits [i*data_width +: data_width]
req_ready  output  num_req  per-requester beat accepted this cycle
fifo_full  input  1  FIFO full flag
fifo_w_en  output  1  FIFO write enable
fifo_data_in  output  data_width  FIFO write data
grant_id  output  $clog2(num_req)  index of current/last granted requester
busy  output  1  1 while in GRANT state

Behaviour:
- Reset (clr_n low, asynchronous, takes effect immediately):
  - state=IDLE, grant_id=0, beat_cnt=0, last_grant=num_req-1 (requester 0 has first priority).
  - All outputs forced low: req_ready=0, fifo_w_en=0, fifo_data_in=0, busy=0.
  - Deassertion is sampled on the next rising edge.
- State machine, two states:
  - IDLE: req_ready=0, fifo_w_en=0. If any req_valid=1 at a rising edge, pick the first set bit scanning last_grant+1, +2, ... modulo num_req. Load grant_id, clear beat_cnt, go to GRANT. Arbitration latency is 1 cycle from valid to grant.
  - GRANT (busy=1):
    - req_ready[grant_id] = !fifo_full, combinational; all other req_ready bits = 0.
    - Transfer when req_valid[grant_id] && req_ready[grant_id].
    - fifo_w_en = transfer, combinational, same cycle.
    - fifo_data_in = req_data slice of grant_id whenever busy, else 0.
    - Each transfer increments beat_cnt; beat_cnt width is $clog2(max_burst+1).
- Release from GRANT to IDLE at a rising edge, with last_grant <= grant_id, on any of:
  - (a) transfer with req_last[grant_id]=1;
  - (b) transfer that makes beat_cnt reach max_burst;
  - (c) req_valid[grant_id]=0, i.e. the requester stalls. Does not apply while fifo_full=1 and valid is held.
- fifo_full=1 during GRANT: no transfer, grant is held, beat_cnt unchanged. The arbiter never asserts fifo_w_en while fifo_full=1.
- grant_id holds its last value in IDLE.
- Re-arbitration costs 1 IDLE cycle per grant; peak throughput is max_burst beats per max_burst+1 cycles.
- Requesters must hold data/last stable while valid=1 and ready=0. The arbiter does not check this.
- Requester fairness: after release, the released requester has lowest priority at the next arbitration.
- Simultaneous release and new requests: release always goes through IDLE; the new grant is decided in IDLE on the next edge.
- Reset mid-burst: the in-flight beat is not written, because w_en drops immediately. The packet is truncated and no recovery is attempted.

Test Plan:
- Reset: hold clr_n=0 with all req_valid=1 -> req_ready=0, fifo_w_en=0, busy=0. First grant after release is requester 0, busy=1 one cycle after the first edge with clr_n=1.
- Single requester: req 2 sends 3 beats 0xA1,0xA2,0xA3 with last on 0xA3, fifo_full=0 -> grant_id=2; fifo_w_en high 3 consecutive cycles with data A1,A2,A3; then IDLE for 1 cycle.
- Round-robin: all 4 requesters continuously valid, 1-beat packets (last=1) -> grant order 0,1,2,3,0,1...; each grant is 2 cycles (GRANT+IDLE).
- Burst limit: req 1 valid for 10 beats, last never asserted, other requesters idle -> released after beats 4 and 8, regranted each time; all 10 beats written in order with an IDLE cycle after beats 4 and 8.
- Back-pressure: fifo_full=1 for 3 cycles mid-packet -> req_ready=0 and fifo_w_en=0 those cycles, grant_id unchanged, beat_cnt unchanged; packet resumes with no beat lost or duplicated.
- Stall and async reset: granted requester drops valid -> IDLE next edge, next requester granted. Separately, clr_n pulsed low mid-burst between clock edges -> outputs go low immediately, before the next edge.
